// File: rtl/mp_add_seq_pkg.sv
// rtl/mp_add_seq_pkg.sv - shared types, defaults and helpers for the multi-precision sequencer
package mp_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_NWORDS = 4;

  // Word index width; a single-word configuration still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// rtl/mp_add_seq_if.sv - request/response handshake bundle for the sequencer
interface mp_add_seq_if #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic [WORD_W*NWORDS-1:0] req_a;
  logic [WORD_W*NWORDS-1:0] req_b;
  logic                     req_sub;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WORD_W*NWORDS-1:0] rsp_sum;
  logic                     rsp_cout;
  logic                     rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/mp_add_seq_add_slice.sv
// rtl/mp_add_seq_add_slice.sv - combinational WORD_W-bit adder exposing carry into and out of the MSB
module add_slice #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              c_msb
);
  logic [WORD_W-1:0] low;
  logic [1:0]        top;

  // Split at the MSB so the carry into it is visible for overflow detection.
  always_comb begin
    low   = {1'b0, a[WORD_W-2:0]} + {1'b0, b[WORD_W-2:0]} + WORD_W'(cin);
    c_msb = low[WORD_W-1];
    top   = {1'b0, a[WORD_W-1]} + {1'b0, b[WORD_W-1]} + {1'b0, c_msb};
    sum   = {top[0], low[WORD_W-2:0]};
    cout  = top[1];
  end
endmodule

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - word-serial wide add/subtract over one shared adder slice
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int NWORDS = DEF_NWORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  mp_add_seq_if.slave  bus,
  output logic         busy
);
  localparam int IDX_W = idx_width(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q;
  logic                           carry_q;
  logic                           sub_q;
  logic [NWORDS-1:0][WORD_W-1:0]  a_q;
  logic [NWORDS-1:0][WORD_W-1:0]  b_q;
  logic [NWORDS-1:0][WORD_W-1:0]  sum_q;
  logic                           cout_q;
  logic                           ovf_q;

  logic [WORD_W-1:0]              slice_sum;
  logic                           slice_cout;
  logic                           slice_c_msb;
  logic                           last_word;

  assign last_word = (idx_q == LAST_IDX);

  // Subtraction is A + ~B + 1: the +1 enters through the carry seeded at accept.
  add_slice #(.WORD_W(WORD_W)) u_slice (
    .a     (a_q[idx_q]),
    .b     (b_q[idx_q] ^ {WORD_W{sub_q}}),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_c_msb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE always returns through IDLE before the next accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = RUN;
      RUN:     if (last_word)     state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-word result write-back and carry chaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            sub_q   <= bus.req_sub;
            idx_q   <= '0;
            carry_q <= bus.req_sub;
          end
        end
        RUN: begin
          sum_q[idx_q] <= slice_sum;
          carry_q      <= slice_cout;
          if (last_word) begin
            cout_q <= slice_cout;
            ovf_q  <= slice_c_msb ^ slice_cout;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_ovf   = ovf_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer that time-multiplexes one 16-bit adder slice over NWORDS operand words, least-significant word first.
- Each cycle it feeds the slice one word pair, chaining the carry through a register.
- Gives wide (e.g. 64-bit) arithmetic at the area cost of one 16-bit adder.
- Sits between a request producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WORD_W, 16: width of the shared adder slice, in bits.
- NWORDS, 4: number of words per operand; total operand width is WORD_W*NWORDS.

Ports:
- clk  in  1  clock, single domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  WORD_W*NWORDS  operand A, unsigned or two's complement.
- req_b  in  WORD_W*NWORDS  operand B.
- req_sub  in  1  0 = A+B, 1 = A-B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  WORD_W*NWORDS  result, modulo 2^(WORD_W*NWORDS).
- rsp_cout  out  1  carry out of the top word; for subtract, 1 = no borrow.
- rsp_ovf  out  1  signed overflow.
- busy  out  1  state is not IDLE.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - req_ready = 1, rsp_valid = 0, busy = 0.
  - rsp_sum, rsp_cout, rsp_ovf = 0.
  - Word index and carry register = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid at a clock edge: latch req_a, req_b, req_sub; word index := 0; carry := req_sub; go to RUN.
- RUN:
  - req_ready = 0.
  - Each cycle the slice computes a_word[i] + (b_word[i] XOR {WORD_W{sub}}) + carry.
  - At the edge: sum word i is written into the result register, carry := slice cout, index i := i+1.
  - After the word NWORDS-1 edge: record rsp_cout = final carry and rsp_ovf; go to DONE.
- DONE:
  - rsp_valid = 1; rsp_sum, rsp_cout, rsp_ovf are held stable.
  - On rsp_ready: go to IDLE.
  - No bypass path from DONE to RUN; the next accept happens in IDLE at the earliest one cycle later.
- Latency: exactly NWORDS cycles from the accepting edge to rsp_valid = 1. Throughput: one op per NWORDS+2 cycles minimum.
- Overflow: ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted B when subtracting. Equivalently, carry into the MSB XOR carry out of the MSB, taken from the slice.
- Request-side boundaries:
  - req_valid while not IDLE: ignored, no state change; the producer must hold the request until req_ready.
  - Request operand inputs are don't-care outside IDLE.
- Response-side boundaries:
  - rsp_ready while not DONE: ignored.
  - rsp_ready held low in DONE: wait indefinitely, outputs frozen.
- Index wrap: the index counter is sized clog2(NWORDS), minimum 1 bit. It is never incremented past NWORDS-1 and is reset to 0 on accept.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and no rsp_valid pulse is produced.
- NWORDS = 1: RUN lasts one cycle; latency 1.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE}.
  - Default WORD_W/NWORDS localparams.
  - Helper function for the index width (clog2 with minimum 1).
- Sub-module add_slice:
  - Purely combinational WORD_W-bit adder.
  - Inputs a, b, cin. Outputs sum, cout, c_msb (carry into the MSB).
  - The only arithmetic in the block. The sequencer contains only muxing, registers and the FSM.

Test Plan (NWORDS=4, WORD_W=16):
- Add all-ones to 1: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, sub=0 -> sum=0, cout=1, ovf=0; rsp_valid rises exactly 4 cycles after accept; req_ready=0 throughout.
- Borrow: A=0, B=1, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0. Also A=0x8000_0000_0000_0000, B=1, sub=1 -> ovf=1.
- Backpressure: hold rsp_ready=0 for 6 cycles in DONE -> outputs stable, req_ready=0. A second req_valid with A=B=0x1234 is not accepted until one cycle after rsp_ready; that request then returns 0x2468.
- Reset mid-RUN: assert rst_n=0 two cycles after accept -> all outputs at reset values immediately; no rsp_valid. A new request after release completes normally.
- Random regression: 1000 random A/B/sub against a 64-bit reference model, with random rsp_ready gaps -> every sum, cout and ovf matches.
